barrel_shifter_pipe: RTL and testbench
======================================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, data width; legal values are powers of two >= 4.
REQ-002 The module SHALL have parameter USER_W, default 4, width of the sideband tag carried alongside the data.
REQ-003 The module SHALL use derived constant SW = $clog2(WIDTH) for shift-amount width and pipeline depth.
REQ-004 The module SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The module SHALL have port i_valid, input, 1, input beat valid.
REQ-007 The module SHALL have port o_ready, output, 1, input beat accepted when i_valid && o_ready.
REQ-008 The module SHALL have port i_data, input, WIDTH, operand.
REQ-009 The module SHALL have port i_ctrl, input, 3, shift mode.
REQ-010 The module SHALL have port i_amt, input, SW, shift amount.
REQ-011 The module SHALL have port i_user, input, USER_W, sideband tag.
REQ-012 The module SHALL have port o_valid, output, 1, result valid.
REQ-013 The module SHALL have port i_ready, input, 1, downstream ready.
REQ-014 The module SHALL have port o_data, output, WIDTH, shifted result.
REQ-015 The module SHALL have port o_user, output, USER_W, tag of the result beat.
REQ-016 The module SHALL have port o_illegal, output, 1, set on a result beat whose ctrl was 101 or 111.

Function
REQ-017 Modes SHALL be: 000 pass; 001 logical right, zero fill; 010 arithmetic right, MSB fill; 011 rotate right; 100 logical left, zero fill; 110 rotate left; 101 and 111 pass with o_illegal=1.
REQ-018 Shift amount 0 SHALL yield o_data == i_data for every mode.
REQ-019 Rotate SHALL wrap modulo WIDTH: an amount of WIDTH-1 rotates by WIDTH-1 positions with no bits lost.
REQ-020 The datapath SHALL be SW registered stages; stage k (k=0..SW-1) conditionally shifts by 2^k when amt bit k is set.
REQ-021 Each stage SHALL register data, ctrl, amt, user, illegal and valid; o_* SHALL be driven directly from the last stage's registers.
REQ-022 Latency SHALL be exactly SW cycles from an accepted input beat to o_valid, absent backpressure.
REQ-023 Throughput SHALL be one beat per cycle while i_ready=1.
REQ-024 Stage k SHALL load when its register is empty or stage k+1 accepts in the same cycle; the last stage's downstream acceptance is i_ready.
REQ-025 o_ready SHALL equal the stage-0 load condition: bubbles are collapsed, and a full pipeline stalls only while i_ready=0.
REQ-026 Under backpressure with o_valid=1 and i_ready=0, o_data, o_user and o_illegal SHALL hold stable until the beat is accepted.
REQ-027 Ordering SHALL be preserved; no beat is dropped or duplicated; at most SW beats are in flight.
REQ-028 Simultaneous output accept and input accept on a full pipeline SHALL advance all stages in one cycle.
REQ-029 Beats with i_valid=0 SHALL never produce an o_valid beat, whatever the values on the other input ports.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously clear all stage valid bits, so o_valid=0, o_illegal=0, o_data=0 and o_user=0.
REQ-031 While rst_n is low, o_ready SHALL be 0.
REQ-032 o_ready SHALL rise in the first clock edge after rst_n deasserts.
REQ-033 Reset mid-operation SHALL discard all in-flight beats; no partial result appears after reset.
REQ-034 Data and tag registers in the stages need not be reset beyond the output stage.

Verification
REQ-035 WIDTH=8, i_ctrl=010, i_data=8'h96, i_amt=3 -> exactly 3 cycles later o_data=8'hF2, o_illegal=0.
REQ-036 WIDTH=8: ctrl 011, data 8'h81, amt 1 -> 8'hC0; ctrl 110, same data and amt -> 8'h03; ctrl 001 -> 8'h40; ctrl 100 -> 8'h02.
REQ-037 Stream 20 back-to-back beats with i_ready=1 -> 20 consecutive o_valid cycles, in order, with the user tags matching.
REQ-038 Fill the pipeline, then hold i_ready=0 for 5 cycles -> o_ready=0 after SW beats, the output stays stable, and on release there is no loss or duplication.
REQ-039 ctrl=101, data 8'h5A -> o_data=8'h5A, o_illegal=1 for that beat only.
REQ-040 Assert rst_n low with 3 beats in flight -> o_valid=0 immediately, and no stale beat is emitted after release.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, with
// valid/ready flow control that collapses bubbles and stalls only when full.
`timescale 1ns/1ps
module barrel_shifter_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int USER_W = 4,
  localparam int SW     = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [2:0]        i_ctrl,
  input  logic [SW-1:0]     i_amt,
  input  logic [USER_W-1:0] i_user,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WIDTH-1:0]  o_data,
  output logic [USER_W-1:0] o_user,
  output logic              o_illegal
);

  logic [WIDTH-1:0]  data_q [SW];
  logic [2:0]        ctrl_q [SW];
  logic [SW-1:0]     amt_q  [SW];
  logic [USER_W-1:0] user_q [SW];
  logic [SW-1:0]     vld_q;
  logic [SW-1:0]     ill_q;
  logic              rdy_q;

  logic [WIDTH-1:0]  data_d [SW];
  logic [2:0]        ctrl_d [SW];
  logic [SW-1:0]     amt_d  [SW];
  logic [USER_W-1:0] user_d [SW];
  logic [SW-1:0]     vld_d;
  logic [SW-1:0]     ill_d;
  logic [SW-1:0]     ld;
  logic [SW-1:0]     en;

  function automatic logic [WIDTH-1:0] shiftBy(input logic [WIDTH-1:0] d,
                                               input logic [2:0] mode,
                                               input int s);
    logic [WIDTH-1:0] r;
    case (mode)
      3'b001:  r = d >> s;
      3'b010:  r = $signed(d) >>> s;
      3'b011:  r = (d >> s) | (d << (WIDTH - s));
      3'b100:  r = d << s;
      3'b110:  r = (d << s) | (d >> (WIDTH - s));
      default: r = d;
    endcase
    return r;
  endfunction

  // Stage k may load if any stage from k to the output is empty, or the output drains.
  always_comb begin
    logic allFull;
    allFull = 1'b1;
    ld      = '0;
    for (int k = SW - 1; k >= 0; k--) begin
      allFull = allFull & vld_q[k];
      ld[k]   = i_ready | ~allFull;
    end
  end

  assign o_ready = rdy_q & ld[0];

  for (genvar k = 0; k < SW; k++) begin : g_stage
    logic [WIDTH-1:0]  srcData;
    logic [2:0]        srcCtrl;
    logic [SW-1:0]     srcAmt;
    logic [USER_W-1:0] srcUser;
    logic              srcVld;
    logic              srcIll;

    if (k == 0) begin : g_head
      assign srcData = i_data;
      assign srcCtrl = i_ctrl;
      assign srcAmt  = i_amt;
      assign srcUser = i_user;
      assign srcVld  = i_valid;
      assign srcIll  = (i_ctrl == 3'b101) || (i_ctrl == 3'b111);
      assign en[k]   = o_ready;
    end else begin : g_body
      assign srcData = data_q[k-1];
      assign srcCtrl = ctrl_q[k-1];
      assign srcAmt  = amt_q[k-1];
      assign srcUser = user_q[k-1];
      assign srcVld  = vld_q[k-1];
      assign srcIll  = ill_q[k-1];
      assign en[k]   = ld[k];
    end

    assign data_d[k] = srcAmt[k] ? shiftBy(srcData, srcCtrl, 1 << k) : srcData;
    assign ctrl_d[k] = srcCtrl;
    assign amt_d[k]  = srcAmt;
    assign user_d[k] = srcUser;
    assign vld_d[k]  = srcVld;
    assign ill_d[k]  = srcIll;
  end

  // rdy_q holds o_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      vld_q <= '0;
      ill_q <= '0;
      for (int k = 0; k < SW; k++) begin
        data_q[k] <= '0;
        ctrl_q[k] <= '0;
        amt_q[k]  <= '0;
        user_q[k] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      for (int k = 0; k < SW; k++) begin
        if (en[k]) begin
          vld_q[k]  <= vld_d[k];
          ill_q[k]  <= ill_d[k];
          data_q[k] <= data_d[k];
          ctrl_q[k] <= ctrl_d[k];
          amt_q[k]  <= amt_d[k];
          user_q[k] <= user_d[k];
        end
      end
    end
  end

  assign o_valid   = vld_q[SW-1];
  assign o_data    = data_q[SW-1];
  assign o_user    = user_q[SW-1];
  assign o_illegal = ill_q[SW-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe at WIDTH=8: directed vectors push
// expected beats into a queue that an independent output monitor drains.
`timescale 1ns/1ps
module tb_barrel_shifter_pipe;

  localparam int WIDTH  = 8;
  localparam int USER_W = 4;
  localparam int SW     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_valid;
  logic              o_ready;
  logic [WIDTH-1:0]  i_data;
  logic [2:0]        i_ctrl;
  logic [SW-1:0]     i_amt;
  logic [USER_W-1:0] i_user;
  logic              o_valid;
  logic              i_ready;
  logic [WIDTH-1:0]  o_data;
  logic [USER_W-1:0] o_user;
  logic              o_illegal;

  barrel_shifter_pipe #(.WIDTH(WIDTH), .USER_W(USER_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_ctrl(i_ctrl), .i_amt(i_amt), .i_user(i_user),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_user(o_user), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] user;
    logic       ill;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] c;
    logic [2:0] a;
    logic [7:0] e;
    logic       ill;
  } vec_t;

  vec_t vecs [18] = '{
    '{8'h81, 3'b011, 3'd1, 8'hC0, 1'b0},
    '{8'h81, 3'b110, 3'd1, 8'h03, 1'b0},
    '{8'h81, 3'b001, 3'd1, 8'h40, 1'b0},
    '{8'h81, 3'b100, 3'd1, 8'h02, 1'b0},
    '{8'h5A, 3'b101, 3'd2, 8'h5A, 1'b1},
    '{8'h3C, 3'b111, 3'd5, 8'h3C, 1'b1},
    '{8'h12, 3'b000, 3'd6, 8'h12, 1'b0},
    '{8'hA5, 3'b010, 3'd0, 8'hA5, 1'b0},
    '{8'hA5, 3'b011, 3'd0, 8'hA5, 1'b0},
    '{8'hA5, 3'b100, 3'd0, 8'hA5, 1'b0},
    '{8'h81, 3'b011, 3'd7, 8'h03, 1'b0},
    '{8'h81, 3'b110, 3'd7, 8'hC0, 1'b0},
    '{8'hFF, 3'b100, 3'd7, 8'h80, 1'b0},
    '{8'h80, 3'b010, 3'd7, 8'hFF, 1'b0},
    '{8'h80, 3'b001, 3'd7, 8'h01, 1'b0},
    '{8'h5A, 3'b001, 3'd4, 8'h05, 1'b0},
    '{8'hC3, 3'b110, 3'd3, 8'h1E, 1'b0},
    '{8'h69, 3'b011, 3'd2, 8'h5A, 1'b0}
  };

  beat_t sbQ [$];
  int    errors = 0;
  int    checks = 0;
  int    runLen = 0;
  int    maxRun = 0;
  logic  holdPending = 1'b0;
  beat_t heldBeat;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Output monitor: samples mid-cycle, pops the scoreboard on each handshake.
  always begin
    beat_t exp;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (o_valid) begin
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
      end else begin
        runLen = 0;
      end
      if (holdPending && o_valid) begin
        checkOutput("holdData", o_data, heldBeat.data);
        checkOutput("holdUser", o_user, heldBeat.user);
        checkOutput("holdIllegal", o_illegal, heldBeat.ill);
      end
      holdPending = o_valid && !i_ready;
      if (holdPending) heldBeat = '{o_data, o_user, o_illegal};
      if (o_valid && i_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedBeat: got data %0h user %0h, expected no beat", o_data, o_user);
        end else begin
          exp = sbQ.pop_front();
          checkOutput("outData", o_data, exp.data);
          checkOutput("outUser", o_user, exp.user);
          checkOutput("outIllegal", o_illegal, exp.ill);
        end
      end
    end else begin
      runLen      = 0;
      holdPending = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [7:0] data, input logic [2:0] ctrl, input logic [2:0] amt,
                               input logic [3:0] user, input logic [7:0] expData, input logic expIll);
    int n = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = data;
    i_ctrl  = ctrl;
    i_amt   = amt;
    i_user  = user;
    #1;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: got o_ready 0 expected 1 for data %0h", data);
    end else begin
      sbQ.push_back('{expData, user, expIll});
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbQ.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("drainPending", sbQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    i_ctrl  = '0;
    i_amt   = '0;
    i_user  = '0;

    #12;
    checkOutput("rstValid", o_valid, 0);
    checkOutput("rstReady", o_ready, 0);
    checkOutput("rstData", o_data, 0);
    checkOutput("rstUser", o_user, 0);
    checkOutput("rstIllegal", o_illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("readyBeforeEdge", o_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("readyAfterEdge", o_ready, 1);

    // Latency of a lone beat: o_valid must appear on the third cycle after acceptance.
    applyStimulus(8'h96, 3'b010, 3'd3, 4'h1, 8'hF2, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("latencyCycle%0d", c), o_valid, (c == 3));
    end
    drain();

    foreach (vecs[i])
      applyStimulus(vecs[i].d, vecs[i].c, vecs[i].a, 4'(i), vecs[i].e, vecs[i].ill);
    drain();

    maxRun = 0;
    for (int i = 0; i < 20; i++)
      applyStimulus(8'(i * 11 + 3), 3'b000, 3'(i % 8), 4'(i), 8'(i * 11 + 3), 1'b0);
    drain();
    checkOutput("streamRun", maxRun, 20);

    @(negedge clk);
    i_ready = 1'b0;
    applyStimulus(8'hF0, 3'b001, 3'd2, 4'hA, 8'h3C, 1'b0);
    applyStimulus(8'h0F, 3'b100, 3'd3, 4'hB, 8'h78, 1'b0);
    applyStimulus(8'h36, 3'b011, 3'd4, 4'hC, 8'h63, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checkOutput("stallReady", o_ready, 0);
      checkOutput("stallValid", o_valid, 1);
    end
    @(negedge clk);
    i_ready = 1'b1;
    applyStimulus(8'h01, 3'b110, 3'd7, 4'hD, 8'h80, 1'b0);
    drain();

    // Reset with three beats in flight: everything queued must vanish.
    applyStimulus(8'h11, 3'b100, 3'd1, 4'h3, 8'h22, 1'b0);
    applyStimulus(8'h22, 3'b100, 3'd1, 4'h4, 8'h44, 1'b0);
    applyStimulus(8'h44, 3'b100, 3'd1, 4'h5, 8'h88, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", o_valid, 0);
    checkOutput("midRstReady", o_ready, 0);
    checkOutput("midRstData", o_data, 0);
    checkOutput("midRstUser", o_user, 0);
    sbQ.delete();
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'hEE;
    i_ctrl  = 3'b011;
    @(negedge clk);
    #1;
    checkOutput("rstHeldReady", o_ready, 0);
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Junk on the data inputs with i_valid low must never surface as a beat.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      i_data = 8'($urandom);
      i_ctrl = 3'($urandom);
      i_amt  = 3'($urandom);
      i_user = 4'($urandom);
    end
    checkOutput("idleValid", o_valid, 0);

    applyStimulus(8'h96, 3'b011, 3'd3, 4'h7, 8'hD2, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
